pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_pkg.sv | 16 +
 rtl/hazard_detect.sv | 22 ++
 rtl/pipe_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline controller: FSM state encoding.
package pipe_pkg;

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_REDIRECT  = 2'd1;
    localparam logic [1:0] ST_IMEM_WAIT = 2'd2;
    localparam logic [1:0] ST_HALTED    = 2'd3;

    typedef enum logic [1:0] {
        RUN       = ST_RUN,
        REDIRECT  = ST_REDIRECT,
        IMEM_WAIT = ST_IMEM_WAIT,
        HALTED    = ST_HALTED
    } pipe_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the decode-stage sources and a load in EX.
module hazard_detect (
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       ex_valid,
    input  logic [4:0] ex_rd,
    input  logic       ex_is_load,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_uses_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 & (id_rs2 == ex_rd);
    // x0 is never written, so a load targeting it cannot create a hazard
    assign load_use = id_valid & ex_valid & ex_is_load & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control FSM: PC enable, stage stall/flush/valid steering and stall counter.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_id_valid,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_uses_rs1,
    input  logic             i_id_uses_rs2,
    input  logic             i_ex_valid,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_is_load,
    input  logic             i_ex_redirect,
    input  logic             i_imem_ready,
    input  logic             i_dmem_busy,
    input  logic             i_halt,
    output logic             o_pc_en,
    output logic             o_if_valid,
    output logic             o_if_id_stall,
    output logic             o_if_id_flush,
    output logic             o_id_ex_stall,
    output logic             o_id_ex_flush,
    output logic             o_ex_mem_stall,
    output logic             o_halted,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pipe_state_t      state;
    pipe_state_t      next_state;
    logic             load_use;
    logic [CNT_W-1:0] stall_cnt;

    hazard_detect u_hazard (
        .id_valid    (i_id_valid),
        .id_rs1      (i_id_rs1),
        .id_rs2      (i_id_rs2),
        .id_uses_rs1 (i_id_uses_rs1),
        .id_uses_rs2 (i_id_uses_rs2),
        .ex_valid    (i_ex_valid),
        .ex_rd       (i_ex_rd),
        .ex_is_load  (i_ex_is_load),
        .load_use    (load_use)
    );

    // Mealy control decode in priority order: reset, halted, dmem, redirect, load-use, fetch
    always_comb begin
        o_pc_en        = 1'b1;
        o_if_valid     = 1'b1;
        o_if_id_stall  = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_stall  = 1'b0;
        o_id_ex_flush  = 1'b0;
        o_ex_mem_stall = 1'b0;
        next_state     = state;
        if (i_rst) begin
            o_pc_en       = 1'b0;
            o_if_valid    = 1'b0;
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
            next_state    = RUN;
        end else if (state == HALTED) begin
            o_pc_en        = 1'b0;
            o_if_valid     = 1'b0;
            o_if_id_stall  = 1'b1;
            o_id_ex_stall  = 1'b1;
            o_ex_mem_stall = 1'b1;
            next_state     = HALTED;
        end else if (i_dmem_busy) begin
            // whole pipe frozen; a pending redirect stays in EX and is seen again later
            o_pc_en        = 1'b0;
            o_if_valid     = 1'b0;
            o_if_id_stall  = 1'b1;
            o_id_ex_stall  = 1'b1;
            o_ex_mem_stall = 1'b1;
            next_state     = state;
        end else if (i_ex_redirect) begin
            o_if_valid    = 1'b0;
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
            next_state    = REDIRECT;
        end else if (load_use) begin
            o_pc_en       = 1'b0;
            o_if_valid    = i_imem_ready & (state != REDIRECT);
            o_if_id_stall = 1'b1;
            o_id_ex_flush = 1'b1;
            if ((state == IMEM_WAIT) && !i_imem_ready) begin
                next_state = IMEM_WAIT;
            end else begin
                next_state = RUN;
            end
        end else begin
            case (state)
                REDIRECT: begin
                    o_if_valid = 1'b0;
                    next_state = RUN;
                end
                RUN, IMEM_WAIT: begin
                    if (i_imem_ready) begin
                        next_state = RUN;
                    end else begin
                        o_pc_en       = 1'b0;
                        o_if_valid    = 1'b0;
                        o_if_id_stall = 1'b1;
                        next_state    = IMEM_WAIT;
                    end
                end
                default: begin
                    next_state = RUN;
                end
            endcase
        end
        if (!i_rst && i_halt) begin
            next_state = HALTED;
        end else begin
            next_state = next_state;
        end
    end

    // State register and saturating count of cycles the PC was held
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= RUN;
            stall_cnt <= {CNT_W{1'b0}};
        end else begin
            state <= next_state;
            if (!o_pc_en && (state != HALTED) && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end else begin
                stall_cnt <= stall_cnt;
            end
        end
    end

    assign o_state     = state;
    assign o_halted    = (state == HALTED);
    assign o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (default width plus a 4-bit counter instance).
module tb_pipe_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       ex_valid;
    logic [4:0] ex_rd;
    logic       ex_is_load;
    logic       ex_redirect;
    logic       imem_ready;
    logic       dmem_busy;
    logic       halt;

    logic        pc_en, if_valid, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall;
    logic        halted;
    logic [1:0]  state;
    logic [15:0] stall_cnt;

    logic        s_pc_en, s_if_valid, s_if_id_stall, s_if_id_flush, s_id_ex_stall, s_id_ex_flush;
    logic        s_ex_mem_stall, s_halted;
    logic [1:0]  s_state;
    logic [3:0]  s_stall_cnt;

    logic [6:0]  ctl;
    assign ctl = {pc_en, if_valid, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall};

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] C_RESET = 7'b0001010;
    localparam logic [6:0] C_RUN   = 7'b1100000;
    localparam logic [6:0] C_LOAD  = 7'b0110010;
    localparam logic [6:0] C_REDIR = 7'b1001010;
    localparam logic [6:0] C_RDST  = 7'b1000000;
    localparam logic [6:0] C_DMEM  = 7'b0010101;
    localparam logic [6:0] C_IMEM  = 7'b0010000;
    localparam logic [6:0] C_HALT  = 7'b0010101;

    pipe_ctrl dut (
        .i_clk(clk), .i_rst(rst),
        .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2),
        .i_ex_valid(ex_valid), .i_ex_rd(ex_rd), .i_ex_is_load(ex_is_load),
        .i_ex_redirect(ex_redirect), .i_imem_ready(imem_ready),
        .i_dmem_busy(dmem_busy), .i_halt(halt),
        .o_pc_en(pc_en), .o_if_valid(if_valid), .o_if_id_stall(if_id_stall),
        .o_if_id_flush(if_id_flush), .o_id_ex_stall(id_ex_stall),
        .o_id_ex_flush(id_ex_flush), .o_ex_mem_stall(ex_mem_stall),
        .o_halted(halted), .o_state(state), .o_stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) dut_sat (
        .i_clk(clk), .i_rst(rst),
        .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2),
        .i_ex_valid(ex_valid), .i_ex_rd(ex_rd), .i_ex_is_load(ex_is_load),
        .i_ex_redirect(ex_redirect), .i_imem_ready(imem_ready),
        .i_dmem_busy(dmem_busy), .i_halt(halt),
        .o_pc_en(s_pc_en), .o_if_valid(s_if_valid), .o_if_id_stall(s_if_id_stall),
        .o_if_id_flush(s_if_id_flush), .o_id_ex_stall(s_id_ex_stall),
        .o_id_ex_flush(s_id_ex_flush), .o_ex_mem_stall(s_ex_mem_stall),
        .o_halted(s_halted), .o_state(s_state), .o_stall_cnt(s_stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs();
        id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_valid = 1'b0; ex_rd = 5'd0; ex_is_load = 1'b0;
        ex_redirect = 1'b0; imem_ready = 1'b1; dmem_busy = 1'b0; halt = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (ctl !== C_RESET) begin bad++; $display("FAIL reset_ctl got=%b want=%b", ctl, C_RESET); end
        total++;
        if ({halted, state, stall_cnt} !== {1'b0, 2'd0, 16'd0}) begin
            bad++; $display("FAIL reset_regs got halted=%b state=%0d cnt=%0d", halted, state, stall_cnt);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (ctl !== C_RUN) begin bad++; $display("FAIL run_ctl got=%b want=%b", ctl, C_RUN); end
        next_cycle();
    endtask

    task automatic test_load_use();
        logic [15:0] c0;
        c0 = stall_cnt;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
        id_valid = 1'b1; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        @(negedge clk);
        total++;
        if (ctl !== C_LOAD) begin bad++; $display("FAIL load_use_ctl got=%b want=%b", ctl, C_LOAD); end
        next_cycle();
        total++;
        if (stall_cnt !== c0 + 16'd1) begin bad++; $display("FAIL load_use_cnt got=%0d want=%0d", stall_cnt, c0 + 16'd1); end
        ex_rd = 5'd0; id_rs1 = 5'd0;
        @(negedge clk);
        total++;
        if (ctl !== C_RUN) begin bad++; $display("FAIL load_use_x0 got=%b want=%b", ctl, C_RUN); end
        next_cycle();
        ex_rd = 5'd9; id_rs1 = 5'd3; id_rs2 = 5'd9; id_uses_rs2 = 1'b1;
        @(negedge clk);
        total++;
        if (ctl !== C_LOAD) begin bad++; $display("FAIL load_use_rs2 got=%b want=%b", ctl, C_LOAD); end
        next_cycle();
        ex_is_load = 1'b0;
        @(negedge clk);
        total++;
        if (ctl !== C_RUN) begin bad++; $display("FAIL load_use_notload got=%b want=%b", ctl, C_RUN); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_redirect();
        ex_redirect = 1'b1;
        @(negedge clk);
        total++;
        if (ctl !== C_REDIR) begin bad++; $display("FAIL redirect_ctl got=%b want=%b", ctl, C_REDIR); end
        next_cycle();
        ex_redirect = 1'b0;
        @(negedge clk);
        total++;
        if ({state, ctl} !== {2'd1, C_RDST}) begin
            bad++; $display("FAIL redirect_state got=%0d/%b want=1/%b", state, ctl, C_RDST);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if ({state, ctl} !== {2'd0, C_RUN}) begin
            bad++; $display("FAIL redirect_back got=%0d/%b want=0/%b", state, ctl, C_RUN);
        end
        next_cycle();
    endtask

    task automatic test_dmem_stall();
        logic [15:0] c0;
        c0 = stall_cnt;
        dmem_busy = 1'b1; ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (ctl !== C_DMEM) begin bad++; $display("FAIL dmem_ctl cyc=%0d got=%b want=%b", i, ctl, C_DMEM); end
            next_cycle();
        end
        dmem_busy = 1'b0;
        @(negedge clk);
        total++;
        if (ctl !== C_REDIR) begin bad++; $display("FAIL dmem_release got=%b want=%b", ctl, C_REDIR); end
        total++;
        if (stall_cnt !== c0 + 16'd3) begin bad++; $display("FAIL dmem_cnt got=%0d want=%0d", stall_cnt, c0 + 16'd3); end
        next_cycle();
        ex_redirect = 1'b0;
        next_cycle();
    endtask

    task automatic test_imem_wait();
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (ctl !== C_IMEM) begin bad++; $display("FAIL imem_ctl cyc=%0d got=%b want=%b", i, ctl, C_IMEM); end
            if (i > 0) begin
                total++;
                if (state !== 2'd2) begin bad++; $display("FAIL imem_state cyc=%0d got=%0d want=2", i, state); end
            end
            next_cycle();
        end
        imem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (ctl !== C_RUN) begin bad++; $display("FAIL imem_ready_ctl got=%b want=%b", ctl, C_RUN); end
        next_cycle();
        total++;
        if (state !== 2'd0) begin bad++; $display("FAIL imem_exit got=%0d want=0", state); end
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        imem_ready = 1'b0;
        for (int i = 0; i < 20; i++) next_cycle();
        total++;
        if (s_stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_cnt got=%0d want=15", s_stall_cnt); end
        total++;
        if (stall_cnt !== 16'd20) begin bad++; $display("FAIL wide_cnt got=%0d want=20", stall_cnt); end
        imem_ready = 1'b1;
        next_cycle();
        total++;
        if (s_stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d want=15", s_stall_cnt); end
    endtask

    task automatic test_halt();
        logic [15:0] c0;
        halt = 1'b1;
        next_cycle();
        halt = 1'b0;
        c0 = stall_cnt;
        for (int i = 0; i < 10; i++) begin
            ex_redirect = i[0];
            dmem_busy   = i[1];
            imem_ready  = i[2];
            @(negedge clk);
            total++;
            if ({halted, state, ctl} !== {1'b1, 2'd3, C_HALT}) begin
                bad++; $display("FAIL halt_hold cyc=%0d got=%b/%0d/%b want=1/3/%b", i, halted, state, ctl, C_HALT);
            end
            next_cycle();
        end
        total++;
        if (stall_cnt !== c0) begin bad++; $display("FAIL halt_cnt got=%0d want=%0d", stall_cnt, c0); end
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({halted, state, stall_cnt, ctl} !== {1'b0, 2'd0, 16'd0, C_RESET}) begin
            bad++; $display("FAIL async_rst got=%b/%0d/%0d/%b", halted, state, stall_cnt, ctl);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({state, ctl} !== {2'd0, C_RUN}) begin bad++; $display("FAIL post_rst got=%0d/%b", state, ctl); end
        next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_load_use();
        test_redirect();
        test_dmem_stall();
        test_imem_wait();
        test_saturation();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
